// File: rtl/draw_rect_ctl.sv
// draw_rect_ctl: rectangle-position controller for draw_rect.
//   Idle: the rectangle tracks the mouse (y clamped to the floor).
//   Left click: the rectangle drops under gravity, bounces with damping and comes to rest.
//   Motion advances once per frame, on the start of vertical blanking.
// Ports:
//   clk          pixel clock
//   rst          asynchronous active-low reset
//   vblnk        vertical blank from vga_timing
//   mouse_left   starts a drop (IDLE only)
//   mouse_right  returns to IDLE from any state (highest priority)
//   mouse_xpos   mouse x position
//   mouse_ypos   mouse y position
//   xpos, ypos   rectangle top-left corner, to draw_rect
//   moving       high while falling or rising
module draw_rect_ctl #(
  parameter int unsigned SCREEN_H   = 600,
  parameter int unsigned RECT_H     = 64,
  parameter int unsigned GRAVITY    = 1,
  parameter int unsigned DAMP_SHIFT = 2,
  parameter int unsigned V_MAX      = 31
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        vblnk,
  input  logic        mouse_left,
  input  logic        mouse_right,
  input  logic [11:0] mouse_xpos,
  input  logic [11:0] mouse_ypos,
  output logic [11:0] xpos,
  output logic [11:0] ypos,
  output logic        moving
);

  localparam logic [11:0] FLOOR = 12'(SCREEN_H - RECT_H);
  localparam logic [5:0]  GRAV  = 6'(GRAVITY);
  localparam logic [5:0]  VMAX  = 6'(V_MAX);

  typedef enum logic [1:0] {StIdle, StFall, StRise, StStop} state_e;

  state_e      state_q, state_d;
  logic [11:0] xpos_q, xpos_d;
  logic [11:0] ypos_q, ypos_d;
  logic [5:0]  vel_q, vel_d;
  logic        vblnk_q;
  logic        armed_q;
  logic        moving_q;

  logic        tick;
  logic [11:0] y_clamped;
  logic [12:0] land_sum;
  logic [5:0]  vel_damped;
  logic [6:0]  vel_inc;
  logic [5:0]  vel_fall;

  // armed_q stays low after reset until vblnk has been seen low, so a vblnk that is
  // already high at reset release is not mistaken for a fresh frame start.
  assign tick       = vblnk & ~vblnk_q & armed_q;
  assign y_clamped  = (mouse_ypos > FLOOR) ? FLOOR : mouse_ypos;
  assign land_sum   = {1'b0, ypos_q} + {7'b0, vel_q};
  assign vel_damped = vel_q - (vel_q >> DAMP_SHIFT);
  assign vel_inc    = {1'b0, vel_q} + {1'b0, GRAV};
  assign vel_fall   = (vel_inc > {1'b0, VMAX}) ? VMAX : vel_inc[5:0];

  always_comb begin
    state_d = state_q;
    xpos_d  = xpos_q;
    ypos_d  = ypos_q;
    vel_d   = vel_q;
    if (mouse_right) begin
      state_d = StIdle;
      vel_d   = '0;
      xpos_d  = mouse_xpos;
      ypos_d  = y_clamped;
    end else begin
      unique case (state_q)
        StIdle: begin
          xpos_d = mouse_xpos;
          ypos_d = y_clamped;
          if (tick && mouse_left) begin
            vel_d   = '0;
            state_d = StFall;
          end
        end
        StFall: begin
          if (tick) begin
            if (land_sum >= {1'b0, FLOOR}) begin
              ypos_d = FLOOR;
              if (vel_damped <= GRAV) begin
                vel_d   = '0;
                state_d = StStop;
              end else begin
                vel_d   = vel_damped;
                state_d = StRise;
              end
            end else begin
              ypos_d = ypos_q + {6'b0, vel_q};
              vel_d  = vel_fall;
            end
          end
        end
        StRise: begin
          if (tick) begin
            if (vel_q <= GRAV) begin
              // Apex reached.
              vel_d   = '0;
              state_d = StFall;
            end else begin
              ypos_d = (ypos_q >= {6'b0, vel_q}) ? ypos_q - {6'b0, vel_q} : 12'd0;
              vel_d  = vel_q - GRAV;
            end
          end
        end
        StStop: begin
          ypos_d = FLOOR;
        end
        default: begin
          state_d = StIdle;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= StIdle;
      xpos_q   <= '0;
      ypos_q   <= '0;
      vel_q    <= '0;
      vblnk_q  <= 1'b0;
      armed_q  <= 1'b0;
      moving_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      xpos_q   <= xpos_d;
      ypos_q   <= ypos_d;
      vel_q    <= vel_d;
      vblnk_q  <= vblnk;
      armed_q  <= armed_q | ~vblnk;
      moving_q <= (state_d == StFall) || (state_d == StRise);
    end
  end

  assign xpos   = xpos_q;
  assign ypos   = ypos_q;
  assign moving = moving_q;

endmodule

// File: tb/tb_draw_rect_ctl.sv
// Directed bench for draw_rect_ctl with a scoreboard of expected (xpos, ypos, moving).
module tb_draw_rect_ctl;

  logic        clk;
  logic        rst;
  logic        vblnk;
  logic        mouse_left;
  logic        mouse_right;
  logic [11:0] mouse_xpos;
  logic [11:0] mouse_ypos;
  logic [11:0] xpos;
  logic [11:0] ypos;
  logic        moving;

  draw_rect_ctl dut (
    .clk        (clk),
    .rst        (rst),
    .vblnk      (vblnk),
    .mouse_left (mouse_left),
    .mouse_right(mouse_right),
    .mouse_xpos (mouse_xpos),
    .mouse_ypos (mouse_ypos),
    .xpos       (xpos),
    .ypos       (ypos),
    .moving     (moving)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [11:0] x;
    logic [11:0] y;
    logic        m;
  } obs_t;

  obs_t  exp_q[$];
  string tag_q[$];
  int    n_checks = 0;
  int    n_fail   = 0;

  // Reference model of the motion rules (0 idle, 1 fall, 2 rise, 3 stop).
  int m_state;
  int m_y;
  int m_vel;

  task automatic model_tick();
    int nv;
    if (m_state == 1) begin
      if (m_y + m_vel >= 536) begin
        m_y = 536;
        nv  = m_vel - (m_vel >> 2);
        if (nv <= 1) begin
          m_vel   = 0;
          m_state = 3;
        end else begin
          m_vel   = nv;
          m_state = 2;
        end
      end else begin
        m_y   = m_y + m_vel;
        m_vel = (m_vel + 1 > 31) ? 31 : m_vel + 1;
      end
    end else if (m_state == 2) begin
      if (m_vel <= 1) begin
        m_vel   = 0;
        m_state = 1;
      end else begin
        m_y   = (m_y >= m_vel) ? m_y - m_vel : 0;
        m_vel = m_vel - 1;
      end
    end
  endtask

  task automatic push(input string tag, input int x, input int y, input logic m);
    obs_t e;
    e.x = 12'(x);
    e.y = 12'(y);
    e.m = m;
    exp_q.push_back(e);
    tag_q.push_back(tag);
  endtask

  task automatic check();
    obs_t  e;
    obs_t  o;
    string t;
    n_checks++;
    if (exp_q.size() == 0) begin
      n_fail++;
      $error("FAIL scoreboard_empty: observed no expected entry, required one");
    end else begin
      e = exp_q.pop_front();
      t = tag_q.pop_front();
      o = '{x: xpos, y: ypos, m: moving};
      assert (o === e)
      else begin
        n_fail++;
        $error("FAIL %s: observed x=%0d y=%0d moving=%0b, expected x=%0d y=%0d moving=%0b",
               t, o.x, o.y, o.m, e.x, e.y, e.m);
      end
    end
  endtask

  // One frame start: vblnk rises, the tick edge updates, outputs are checked, vblnk drops.
  task automatic frame();
    @(negedge clk) vblnk = 1'b1;
    @(posedge clk);
    #1 check();
    @(negedge clk) vblnk = 1'b0;
    @(negedge clk);
  endtask

  int exp_y[15] = '{500, 501, 503, 506, 510, 515, 521, 528, 536, 530, 525, 521, 518, 516, 516};

  initial begin
    rst         = 1'b0;
    vblnk       = 1'b0;
    mouse_left  = 1'b0;
    mouse_right = 1'b0;
    mouse_xpos  = 12'd100;
    mouse_ypos  = 12'd200;
    repeat (2) @(posedge clk);
    #1 push("reset", 0, 0, 1'b0);
    check();

    @(negedge clk) rst = 1'b1;
    push("track", 100, 200, 1'b0);
    @(posedge clk);
    #1 check();

    @(negedge clk) mouse_ypos = 12'd590;
    push("clamp", 100, 536, 1'b0);
    @(posedge clk);
    #1 check();

    // Drop from (300,500) through the first bounce and apex.
    @(negedge clk);
    mouse_xpos = 12'd300;
    mouse_ypos = 12'd500;
    @(negedge clk) mouse_left = 1'b1;
    push("drop_start", 300, 500, 1'b1);
    frame();
    mouse_left = 1'b0;
    for (int i = 0; i < 15; i++) begin
      push($sformatf("drop_tick%0d", i + 1), 300, exp_y[i], 1'b1);
      frame();
    end

    // Further bounces against the model, stopping mid-rise.
    m_state = 1;
    m_y     = 516;
    m_vel   = 0;
    for (int i = 0; i < 40; i++) begin
      if (i >= 8 && m_state == 2 && m_vel > 1) break;
      model_tick();
      push($sformatf("bounce%0d", i), 300, m_y, (m_state == 1 || m_state == 2));
      frame();
    end

    // Right click on a tick edge mid-rise: back to IDLE, no motion step.
    @(negedge clk);
    mouse_xpos  = 12'd50;
    mouse_ypos  = 12'd100;
    mouse_right = 1'b1;
    vblnk       = 1'b1;
    push("right_tick", 50, 100, 1'b0);
    @(posedge clk);
    #1 check();
    @(negedge clk);
    mouse_right = 1'b0;
    vblnk       = 1'b0;
    mouse_xpos  = 12'd60;
    push("right_follow", 60, 100, 1'b0);
    @(posedge clk);
    #1 check();

    // Short drop from just above the floor ends in STOP.
    @(negedge clk);
    mouse_xpos = 12'd300;
    mouse_ypos = 12'd535;
    @(negedge clk) mouse_left = 1'b1;
    push("stop_start", 300, 535, 1'b1);
    frame();
    mouse_left = 1'b0;
    push("stop_fall", 300, 535, 1'b1);
    frame();
    push("stop_land", 300, 536, 1'b0);
    frame();
    mouse_xpos = 12'd10;
    mouse_ypos = 12'd20;
    mouse_left = 1'b1;
    push("stop_hold", 300, 536, 1'b0);
    frame();
    mouse_left = 1'b0;
    @(negedge clk) mouse_right = 1'b1;
    @(negedge clk) mouse_right = 1'b0;

    // Asynchronous reset mid-fall, released with vblnk high.
    mouse_xpos = 12'd300;
    mouse_ypos = 12'd500;
    @(negedge clk) mouse_left = 1'b1;
    push("rst_drop", 300, 500, 1'b1);
    frame();
    mouse_left = 1'b0;
    push("rst_fall", 300, 500, 1'b1);
    frame();
    @(posedge clk);
    #2 rst = 1'b0;
    #2 push("rst_async", 0, 0, 1'b0);
    check();
    vblnk      = 1'b1;
    mouse_left = 1'b1;
    mouse_xpos = 12'd70;
    mouse_ypos = 12'd80;
    #4 rst = 1'b1;
    repeat (4) @(posedge clk);
    #1 push("rst_no_tick", 70, 80, 1'b0);
    check();
    @(negedge clk) vblnk = 1'b0;
    @(negedge clk);
    push("rst_rearm", 70, 80, 1'b1);
    frame();
    mouse_left = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: observed no completion, required finish before time limit");
    $fatal(1, "watchdog");
  end

endmodule
